// File: rtl/sram_pkg.sv
// Shared definitions for the pipelined SRAM: FSM state encoding,
// read-latency bounds and the per-byte parity helper.
package sram_pkg;

    // INIT clears the array after reset; RUN serves requests until the next reset.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Legal read-latency range, in clock cycles from accept to RVALID.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Even parity: the stored bit makes the byte plus parity hold an even
    // number of ones, so an all-zero byte carries parity 0.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return shift pipeline for sram_pipe: RD_LAT stages carrying
// valid, data and parity-error flags. Data registers load only when a
// valid word passes, so the last stage holds the most recent read value
// while the pipeline is idle.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    // Out-of-range settings are clamped so the structure always elaborates.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [LAT-1:0]    v_q;
    logic [LAT-1:0]    e_q;
    logic [DATA_W-1:0] d_q [LAT];

    // Shift valid/error every cycle; advance data only alongside a valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            e_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= in_valid;
            e_q[0] <= in_valid & in_err;
            if (in_valid) begin
                d_q[0] <= in_data;
            end
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                e_q[i] <= v_q[i-1] & e_q[i-1];
                if (v_q[i-1]) begin
                    d_q[i] <= d_q[i-1];
                end
            end
        end
    end

    assign out_valid = v_q[LAT-1];
    assign out_data  = d_q[LAT-1];
    assign out_err   = e_q[LAT-1];

endmodule

// File: rtl/sram_pipe.sv
// Single-port pipelined SRAM with byte enables, a self-clearing INIT
// phase after reset and a configurable read latency (RD_LAT).
// Optional feature: define SRAM_PIPE_PARITY_EN to store one even-parity
// bit per byte and flag mismatches on PERR; otherwise PERR is tied low.
//
// Handshake: a request is accepted on a rising edge where req && ready;
// at most one request per cycle, back-to-back accepts allowed. Reads
// return one cycle of rvalid with rdata exactly RD_LAT cycles after the
// accepting edge; writes never produce rvalid. Requests while ready is
// low are ignored entirely.
module sram_pipe
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                wren,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                init_done,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                perr,
    output state_t              fsm_state
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_wr;
    logic              acc_rd;
    logic              rd_req_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_word;
    logic              rd_err;

    assign ready     = (fsm_state == RUN);
    assign init_done = ready;
    assign acc_wr    = req & ready & wren;
    assign acc_rd    = req & ready & ~wren;

    // INIT walks the clear counter up to the last word, then parks in RUN;
    // the counter stops at DEPTH-1 instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state <= INIT;
            init_cnt  <= '0;
        end else begin
            case (fsm_state)
                INIT: begin
                    if (&init_cnt) begin
                        fsm_state <= RUN;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    fsm_state <= RUN;
                end
                default: begin
                    fsm_state <= INIT;
                end
            endcase
        end
    end

    // Register the accepted read address; the array is read from this
    // register in the following cycle, so a write accepted one cycle
    // earlier is already visible (write-first ordering).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_req_q <= acc_rd;
            if (acc_rd) begin
                rd_addr_q <= addr;
            end
        end
    end

    // Array write port: INIT clears one word per cycle, RUN applies byte-enabled writes.
    always_ff @(posedge clk) begin
        if (fsm_state == INIT) begin
            mem[init_cnt] <= '0;
        end else if (acc_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rd_word = mem[rd_addr_q];

`ifdef SRAM_PIPE_PARITY_EN
    logic [NB-1:0] pmem [DEPTH];

    // Parity write port mirrors the data array: cleared words carry parity 0.
    always_ff @(posedge clk) begin
        if (fsm_state == INIT) begin
            pmem[init_cnt] <= '0;
        end else if (acc_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    pmem[addr][i] <= byte_parity(wdata[i*8 +: 8]);
                end
            end
        end
    end

    // Recompute parity of the word being read and flag any byte mismatch.
    always_comb begin
        rd_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (byte_parity(rd_word[i*8 +: 8]) != pmem[rd_addr_q][i]) begin
                rd_err = 1'b1;
            end
        end
    end
`else
    // Without parity storage there is nothing to check.
    assign rd_err = 1'b0;
`endif

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_req_q),
        .in_data   (rd_word),
        .in_err    (rd_err),
        .out_valid (rvalid),
        .out_data  (rdata),
        .out_err   (perr)
    );

endmodule

// File: tb/tb_sram_pipe.sv
// Self-checking bench for sram_pipe (DATA_W=32, ADDR_W=6, RD_LAT=3).
// A plain array models memory contents; each accepted read pushes the
// expected word and return edge onto queues that a negedge monitor
// compares against rvalid/rdata/perr. Compile with SRAM_PIPE_PARITY_EN
// defined to exercise the parity-error path.
module tb_sram_pipe;
    import sram_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 64;
    localparam int NB     = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              req   = 1'b0;
    logic              wren  = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [NB-1:0]     be    = '0;
    logic              ready;
    logic              init_done;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              perr;
    state_t            fsm_state;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q[$];
    int                exp_edge_q[$];
    logic              exp_perr_q[$];
    logic [DATA_W-1:0] last_rdata = '0;
    logic              inj_perr   = 1'b0;
    logic              mon_ev;

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sram_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wren      (wren),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .ready     (ready),
        .init_done (init_done),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .perr      (perr),
        .fsm_state (fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every negedge, rvalid must match the queue head's due edge.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_ev = (exp_q.size() > 0) && (exp_edge_q[0] == edge_cnt);
            chk("rvalid_timing", 32'(rvalid), 32'(mon_ev));
            if (mon_ev) begin
                if (rvalid) begin
                    chk("rdata", rdata, exp_q[0]);
                    chk("perr", 32'(perr), 32'(exp_perr_q[0]));
                end
                last_rdata = exp_q[0];
                void'(exp_q.pop_front());
                void'(exp_edge_q.pop_front());
                void'(exp_perr_q.pop_front());
            end else if (!rvalid) begin
                chk("rdata_hold", rdata, last_rdata);
            end
        end
    end

    // Drive one cycle of inputs (called at a negedge); update the model on accept.
    task automatic drive(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [NB-1:0] b);
        req = r; wren = w; addr = a; wdata = d; be = b;
        if (r && ready) begin
            if (w) begin
                for (int i = 0; i < NB; i++)
                    if (b[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                exp_q.push_back(ref_mem[a]);
                exp_edge_q.push_back(edge_cnt + 1 + RD_LAT);
                exp_perr_q.push_back(inj_perr);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issue a read and wait (bounded) for its return.
    task automatic read_wait(input logic [ADDR_W-1:0] a, input string tag,
                             output logic [DATA_W-1:0] d, output logic e);
        int k = 0;
        drive(1'b1, 1'b0, a, '0, '0);
        req = 1'b0;
        while (!rvalid && k < RD_LAT + 4) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_returned"}, 32'(rvalid), 32'd1);
        d = rdata;
        e = perr;
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, discard outstanding expectations, check reset outputs.
    task automatic reset_assert(input string tag);
        #2;
        rst_n = 1'b0;
        req = 1'b0;
        exp_q.delete();
        exp_edge_q.delete();
        exp_perr_q.delete();
        last_rdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        #1;
        chk({tag, "_rst_ready"}, 32'(ready), 32'd0);
        chk({tag, "_rst_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_rst_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_rst_rdata"}, rdata, 32'd0);
        chk({tag, "_rst_perr"}, 32'(perr), 32'd0);
        chk({tag, "_rst_state"}, 32'(fsm_state), 32'(INIT));
    endtask

    // Release reset and count cycles with ready low, driving ignored requests.
    task automatic release_and_measure(input string tag);
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (ready !== 1'b1 && n < 200) begin
            req   = 1'($urandom_range(0, 1));
            wren  = 1'($urandom_range(0, 1));
            addr  = ADDR_W'($urandom);
            wdata = $urandom;
            be    = NB'($urandom);
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        chk({tag, "_init_cycles"}, 32'(n), 32'd64);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
        chk({tag, "_state_run"}, 32'(fsm_state), 32'(RUN));
    endtask

    logic [DATA_W-1:0] rd;
    logic              pe;
    logic [DATA_W-1:0] seq_vals [3];
    int                acc_edge;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Power-on reset
        repeat (3) @(negedge clk);
        chk("por_ready", 32'(ready), 32'd0);
        chk("por_rvalid", 32'(rvalid), 32'd0);
        chk("por_rdata", rdata, 32'd0);
        chk("por_perr", 32'(perr), 32'd0);
        release_and_measure("por");

        // Cleared memory reads as zero, including both ends of the range
        read_wait(6'd0, "rd_addr0", rd, pe);
        chk("clear_addr0", rd, 32'h0);
        read_wait(6'd63, "rd_addr63", rd, pe);
        chk("clear_addr63", rd, 32'h0);
        read_wait(ADDR_W'($urandom_range(1, 62)), "rd_rand", rd, pe);
        chk("clear_rand", rd, 32'h0);

        // Byte-enable merge
        drive(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 4'b1111);
        drive(1'b1, 1'b1, 6'd5, 32'h11223344, 4'b0101);
        read_wait(6'd5, "rd_be", rd, pe);
        chk("be_merge", rd, 32'hDE22BE44);

        // BE=0 is a no-op
        drive(1'b1, 1'b1, 6'd5, 32'hFFFFFFFF, 4'b0000);
        read_wait(6'd5, "rd_be0", rd, pe);
        chk("be_zero_noop", rd, 32'hDE22BE44);

        // Write-first: read on the cycle right after the write
        drive(1'b1, 1'b1, 6'd9, 32'hA5A5A5A5, 4'b1111);
        read_wait(6'd9, "rd_wf", rd, pe);
        chk("write_first", rd, 32'hA5A5A5A5);

        // Back-to-back reads return on consecutive cycles, in order
        seq_vals[0] = 32'h1111_0001;
        seq_vals[1] = 32'h2222_0002;
        seq_vals[2] = 32'h3333_0003;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, ADDR_W'(i + 1), seq_vals[i], 4'b1111);
        acc_edge = edge_cnt + 1;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, ADDR_W'(i + 1), '0, '0);
        req = 1'b0;
        while (edge_cnt < acc_edge + RD_LAT + 2) begin
            if (edge_cnt >= acc_edge + RD_LAT) begin
                chk("b2b_rvalid", 32'(rvalid), 32'd1);
                chk("b2b_rdata", rdata, seq_vals[edge_cnt - acc_edge - RD_LAT]);
            end else begin
                chk("b2b_early", 32'(rvalid), 32'd0);
            end
            @(negedge clk);
        end
        chk("b2b_last_rvalid", 32'(rvalid), 32'd1);
        chk("b2b_last_rdata", rdata, seq_vals[2]);
        idle(2);

        // Parity check path
        drive(1'b1, 1'b1, 6'd7, 32'h0F0F1234, 4'b1111);
        idle(1);
`ifdef SRAM_PIPE_PARITY_EN
        dut.mem[7][0] = ~dut.mem[7][0];
        ref_mem[7][0] = ~ref_mem[7][0];
        inj_perr = 1'b1;
        read_wait(6'd7, "rd_perr", rd, pe);
        inj_perr = 1'b0;
        chk("perr_flagged", 32'(pe), 32'd1);
        chk("perr_data", rd, 32'h0F0F1235);
`else
        read_wait(6'd7, "rd_perr", rd, pe);
        chk("perr_tied_low", 32'(pe), 32'd0);
        chk("perr_data", rd, 32'h0F0F1234);
`endif

        // Randomized traffic over a narrow address window to force reuse
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ADDR_W'($urandom_range(0, 15)), $urandom, NB'($urandom));
        end
        idle(RD_LAT + 3);

        // Reset in the middle of INIT, with the clear counter at 20
        reset_assert("rst_a");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_init_state", 32'(fsm_state), 32'(INIT));
        chk("mid_init_ready", 32'(ready), 32'd0);
        reset_assert("rst_b");
        release_and_measure("init_abort");

        // Reset with a read in flight: it must never return
        drive(1'b1, 1'b1, 6'd5, 32'hCAFEF00D, 4'b1111);
        drive(1'b1, 1'b0, 6'd5, '0, '0);
        req = 1'b0;
        reset_assert("rst_c");
        release_and_measure("rd_abort");
        read_wait(6'd5, "rd_after_abort", rd, pe);
        chk("cleared_after_abort", rd, 32'h0);

        idle(RD_LAT + 3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
